// File: rtl/regfile_write_sequencer.sv
// Write-queue sequencer for a 32x16 level-sensitive register file.
// Buffers writebacks in order, arbitrates reads vs writes, flags RAW hazards.
module regfile_write_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_req,
    input  logic [ADDR_WIDTH-1:0]   rd_addr1,
    input  logic [ADDR_WIDTH-1:0]   rd_addr2,
    output logic                    rd_grant,
    output logic                    rd_hazard,
    output logic                    rd_data_valid,
    output logic                    select,
    output logic [ADDR_WIDTH-1:0]   readAddress1,
    output logic [ADDR_WIDTH-1:0]   readAddress2,
    output logic [ADDR_WIDTH-1:0]   writeAddress,
    output logic [DATA_WIDTH-1:0]   writeData,
    output logic [$clog2(DEPTH):0]  pending_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                  state_q, state_d;
    logic                    select_q;
    logic                    rd_valid_q;
    logic [ADDR_WIDTH-1:0]   raddr1_q, raddr2_q;
    logic [ADDR_WIDTH-1:0]   waddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [PW-1:0]           rptr_q, wptr_q;
    logic [CW-1:0]           count_q, count_d;

    logic [ADDR_WIDTH-1:0]   q_addr [DEPTH];
    logic [DATA_WIDTH-1:0]   q_data [DEPTH];

    logic                    full, empty;
    logic                    push, pop;
    logic                    hit;
    logic [PW-1:0]           off;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign wr_ready = !reset && !full;
    assign push     = wr_valid && wr_ready;

    // An entry is live when its distance from the head is below the count.
    always_comb begin
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rptr_q;
            if (({1'b0, off} < count_q) &&
                (q_addr[i] == rd_addr1 ||
                 q_addr[i] == rd_addr2))
                hit = 1'b1;
        end
        if (push && (wr_addr == rd_addr1 ||
                     wr_addr == rd_addr2))
            hit = 1'b1;
    end

    assign rd_hazard = rd_req && hit;
    assign rd_grant  = rd_req && !hit && !full;

    always_comb begin
        state_d = IDLE;
        if (full)
            state_d = WRITE;
        else if (rd_req && !hit)
            state_d = READ;
        else if (!empty)
            state_d = WRITE;
    end

    assign pop     = (state_d == WRITE);
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            select_q   <= 1'b1;
            rd_valid_q <= 1'b0;
            raddr1_q   <= '0;
            raddr2_q   <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            select_q   <= (state_d != WRITE);
            rd_valid_q <= (state_d == READ);
            count_q    <= count_d;
            if (rd_grant) begin
                raddr1_q <= rd_addr1;
                raddr2_q <= rd_addr2;
            end
            if (pop) begin
                waddr_q <= q_addr[rptr_q];
                wdata_q <= q_data[rptr_q];
                rptr_q  <= rptr_q + PW'(1);
            end
            if (push)
                wptr_q <= wptr_q + PW'(1);
        end
    end

    // Storage needs no reset: liveness comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wptr_q] <= wr_addr;
            q_data[wptr_q] <= wr_data;
        end
    end

    assign rd_data_valid = rd_valid_q;
    assign select        = select_q;
    assign readAddress1  = raddr1_q;
    assign readAddress2  = raddr2_q;
    assign writeAddress  = waddr_q;
    assign writeData     = wdata_q;
    assign pending_count = count_q;

endmodule
